// File: rtl/dmem_pkg.sv
// Shared encodings and FSM state type for the data-memory controller.
package dmem_pkg;

  localparam logic [2:0] RSEL_LW  = 3'd0;
  localparam logic [2:0] RSEL_LH  = 3'd1;
  localparam logic [2:0] RSEL_LB  = 3'd2;
  localparam logic [2:0] RSEL_LHU = 3'd3;
  localparam logic [2:0] RSEL_LBU = 3'd4;

  localparam logic [1:0] WSEL_SW = 2'd0;
  localparam logic [1:0] WSEL_SH = 2'd1;
  localparam logic [1:0] WSEL_SB = 2'd2;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_ram.sv
// Word-organised 1R1W synchronous SRAM with per-byte write enables and a
// registered read port.
module dmem_ram #(
  parameter int DEPTH_WORDS = 2048,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) begin
        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request port, optional wait states,
// alignment/range checking and RV32 load/store lane handling over dmem_ram.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 2048,
  parameter int IDX_W       = $clog2(DEPTH_WORDS),
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_rsel,
  input  logic [1:0]  req_wsel,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  state_t            state;
  logic [WAIT_W-1:0] cnt;

  logic              we_p0;
  logic [31:0]       addr_p0;
  logic [31:0]       wdata_p0;
  logic [2:0]        rsel_p0;
  logic [1:0]        wsel_p0;

  logic              err;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [IDX_W-1:0]  ram_raddr;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  rsel,
                                              input logic [1:0]  off);
    logic [15:0] half;
    logic [7:0]  bval;
    half = off[1] ? word[31:16] : word[15:0];
    bval = 8'(word >> {off, 3'b000});
    case (rsel)
      RSEL_LH:  return {{16{half[15]}}, half};
      RSEL_LHU: return {16'd0, half};
      RSEL_LB:  return {{24{bval[7]}}, bval};
      RSEL_LBU: return {24'd0, bval};
      default:  return word;
    endcase
  endfunction

  assign req_ready = (state == IDLE);

  always_comb begin
    err = ((addr_p0 >> (IDX_W + 2)) != 32'd0);
    if (we_p0) begin
      case (wsel_p0)
        WSEL_SW: err = err | (addr_p0[1:0] != 2'd0);
        WSEL_SH: err = err | addr_p0[0];
        WSEL_SB: err = err;
        default: err = 1'b1;
      endcase
    end else begin
      case (rsel_p0)
        RSEL_LW:            err = err | (addr_p0[1:0] != 2'd0);
        RSEL_LH, RSEL_LHU:  err = err | addr_p0[0];
        RSEL_LB, RSEL_LBU:  err = err;
        default:            err = 1'b1;
      endcase
    end
  end

  always_comb begin
    ram_be    = 4'b0000;
    ram_wdata = wdata_p0;
    case (wsel_p0)
      WSEL_SW: ram_be = 4'b1111;
      WSEL_SH: begin
        ram_be    = addr_p0[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{wdata_p0[15:0]}};
      end
      WSEL_SB: begin
        ram_be    = 4'b0001 << addr_p0[1:0];
        ram_wdata = {4{wdata_p0[7:0]}};
      end
      default: ram_be = 4'b0000;
    endcase
  end

  // Reads are launched on the edge entering ACCESS so the word is ready
  // during ACCESS; with no wait states that edge is the accept edge itself.
  assign ram_raddr = (state == IDLE) ? req_addr[IDX_W+1:2] : addr_p0[IDX_W+1:2];
  assign ram_we    = (state == ACCESS) && we_p0 && !err && !rst;

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (ram_be),
    .waddr (addr_p0[IDX_W+1:2]),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // ---- p0: request capture ----
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      we_p0    <= req_we;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
      rsel_p0  <= req_rsel;
      wsel_p0  <= req_wsel;
    end
  end

  // ---- control FSM and registered response ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
              cnt   <= WAIT_W'(WAIT_CYCLES - 1);
            end else begin
              state <= ACCESS;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= ACCESS;
          else           cnt   <= cnt - 1'b1;
        end
        ACCESS: begin
          state     <= IDLE;
          rsp_valid <= 1'b1;
          rsp_err   <= err;
          rsp_rdata <= (err || we_p0) ? 32'd0
                                      : load_extend(ram_rdata, rsel_p0, addr_p0[1:0]);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised successor to the single-cycle data memory.
- Word-organised synchronous SRAM behind a valid/ready request port and a one-pulse response port. Supports RV32 load/store widths with sign and zero extension.
- Adds configurable wait states, misalignment and range checking with an error response, and a single-outstanding-request FSM.
- Sits between the LSU/MEM stage and on-chip data storage.

Parameters:
- DEPTH_WORDS, 2048, number of 32-bit words; power of two, at least 2.
- IDX_W, $clog2(DEPTH_WORDS), word-index width; derived, do not override.
- WAIT_CYCLES, 0, extra stall cycles between request accept and the access commit; range 0..15.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_rsel  in  3  load type: 0 = LW, 1 = LH, 2 = LB, 3 = LHU, 4 = LBU; 5..7 are illegal.
- req_wsel  in  2  store type: 0 = SW, 1 = SH, 2 = SB; 3 is illegal.
- rsp_valid  out  1  one-cycle response pulse, for both loads and stores.
- rsp_rdata  out  32  load result; 0 for stores and for errors.
- rsp_err  out  1  request rejected; qualified by rsp_valid.

Behaviour:
- Reset: on a clk edge with rst = 1, FSM goes to IDLE, and req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0. Memory contents are not cleared by rst. Simulation initial value of every word is 0.
- FSM states: IDLE, WAIT, ACCESS.
  - IDLE: req_ready = 1. On req_valid, latch we, addr, wdata, rsel and wsel, then go to WAIT if WAIT_CYCLES > 0, else go to ACCESS.
  - WAIT: counter loads WAIT_CYCLES-1 on entry and decrements each cycle; move to ACCESS when it reaches 0.
  - ACCESS: perform the checks and the memory operation, register the response, return to IDLE.
- req_ready is 0 in WAIT and ACCESS; req_valid is ignored there. Only one request is outstanding at a time.
- Latency: a request accepted on edge T produces rsp_valid = 1 during the cycle after edge T+1+WAIT_CYCLES. rsp_valid is high for exactly one cycle. There is no response backpressure.
- Throughput: one request per 2+WAIT_CYCLES cycles. A new request may be accepted in the cycle in which rsp_valid is high.
- Word index is addr[IDX_W+1:2]. The request is out of range if addr[31:IDX_W+2] != 0.
- Error when any of the following holds:
  - out of range;
  - illegal rsel on a load, or illegal wsel on a store;
  - LW/SW with addr[1:0] != 0;
  - LH/LHU/SH with addr[0] = 1.
- On error: memory is untouched, rsp_err = 1, rsp_rdata = 0.
- Loads:
  - LH/LHU select halfword addr[1]; LB/LBU select byte addr[1:0].
  - LH and LB sign-extend bit 15 / bit 7 respectively.
  - LHU and LBU zero-extend.
- Stores:
  - SW writes the full word.
  - SH writes byte lanes {2·addr[1], 2·addr[1]+1} with wdata[15:0].
  - SB writes lane addr[1:0] with wdata[7:0].
  - All other lanes are unchanged. Use per-lane byte enables, not read-modify-write.
- Store response: rsp_err = 0, rsp_rdata = 0.
- Ordering: a load accepted after a store's rsp_valid observes the stored data.
- rst during WAIT or ACCESS aborts the request. No write occurs unless the ACCESS edge has already completed. rsp_valid is 0 in the following cycle.

Decomposition:
- Package dmem_pkg holds:
  - localparams for the RSel encodings (LW, LH, LB, LHU, LBU) and WSel encodings (SW, SH, SB);
  - the FSM state enum (IDLE, WAIT, ACCESS);
  - the WAIT_CYCLES width constant (4).
- Sub-module dmem_ram: synchronous 1R1W word array, DEPTH_WORDS × 32, with a 4-bit byte-enable write and registered read on the same edge.
- The controller holds the FSM, wait counter, checks, lane steering and load extension.

Test Plan:
- WAIT_CYCLES = 0, SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> each rsp_valid 2 cycles after accept, rdata 0xDEADBEEF, err 0.
- With word 0x10 = 0xDEADBEEF:
  - LB 0x13 -> 0xFFFFFFDE;
  - LBU 0x13 -> 0x000000DE;
  - LH 0x12 -> 0xFFFFDEAD;
  - LHU 0x10 -> 0x0000BEEF.
- SB 0x11 data 0x55, then SH 0x12 data 0x1234, then LW 0x10 -> 0x123455EF.
- LW 0x22 -> err 1, rdata 0. SH 0x21 -> err 1 and word 0x20 unchanged. LW 0x0000_2000 with DEPTH 2048 -> err 1. rsel 5 -> err 1.
- WAIT_CYCLES = 3, back-to-back req_valid -> rsp at accept + 5 cycles, req_ready low 4 cycles, second request accepted in the rsp cycle.
- WAIT_CYCLES = 3, SW accepted, rst asserted 2 cycles later -> no rsp_valid, req_ready = 1 after reset, the word retains its prior value.
